// File: rtl/joystick_reader_pkg.sv
// Shared types and constants for the PmodJSTK joystick poller.
package jstk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } jstk_state_e;

    localparam int         FRAME_BYTES  = 5;
    localparam logic [5:0] CMD_PREFIX   = 6'b100000;
    localparam logic [3:0] NEUTRAL_CODE = 4'd5;
    localparam logic [9:0] CENTRE_RAW   = 10'd352;

endpackage

// File: rtl/joystick_reader_if.sv
// SPI lines between the joystick poller (master) and the PmodJSTK (slave).
interface joystick_reader_if;

    logic Jstk_SS_n;
    logic Jstk_SCK;
    logic Jstk_MOSI;
    logic Jstk_MISO;

    modport master (output Jstk_SS_n, output Jstk_SCK, output Jstk_MOSI, input Jstk_MISO);
    modport slave  (input Jstk_SS_n, input Jstk_SCK, input Jstk_MOSI, output Jstk_MISO);

endinterface

// File: rtl/joystick_reader_spi_byte_shifter.sv
// Mode-0 SPI byte engine. A byte starts with SCK rising on the start cycle
// (MISO sampled there), each bit is SCK_HALF clocks high then SCK_HALF low,
// and done pulses at the end of the final low half.
module spi_byte_shifter #(
    parameter int SCK_HALF = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int            HW          = $clog2(SCK_HALF + 1);
    localparam logic [HW-1:0] HALF_RELOAD = HW'(SCK_HALF - 1);

    logic          busy_q, busy_d;
    logic          sck_q, sck_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sreg_q, sreg_d;
    logic [7:0]    rx_q, rx_d;

    // Before a byte starts MOSI already shows the MSB the top is about to send.
    assign mosi    = busy_q ? sreg_q[7] : tx_byte[7];
    assign sck     = sck_q;
    assign rx_byte = rx_q;
    assign done    = busy_q && !sck_q && (hcnt_q == '0) && (bcnt_q == 3'd0);

    // Half-period sequencing: rise samples MISO, fall advances MOSI.
    always_comb begin
        busy_d = busy_q;
        sck_d  = sck_q;
        hcnt_d = hcnt_q;
        bcnt_d = bcnt_q;
        sreg_d = sreg_q;
        rx_d   = rx_q;
        if (start) begin
            busy_d = 1'b1;
            sck_d  = 1'b1;
            hcnt_d = HALF_RELOAD;
            bcnt_d = 3'd7;
            sreg_d = tx_byte;
            rx_d   = {rx_q[6:0], miso};
        end else if (busy_q) begin
            if (hcnt_q != '0) begin
                hcnt_d = hcnt_q - HW'(1);
            end else if (sck_q) begin
                sck_d  = 1'b0;
                hcnt_d = HALF_RELOAD;
                if (bcnt_q != 3'd0) begin
                    sreg_d = {sreg_q[6:0], 1'b0};
                end
            end else if (bcnt_q == 3'd0) begin
                busy_d = 1'b0;
            end else begin
                bcnt_d = bcnt_q - 3'd1;
                sck_d  = 1'b1;
                hcnt_d = HALF_RELOAD;
                rx_d   = {rx_q[6:0], miso};
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            hcnt_q <= '0;
            bcnt_q <= 3'd0;
            sreg_q <= 8'd0;
            rx_q   <= 8'd0;
        end else begin
            busy_q <= busy_d;
            sck_q  <= sck_d;
            hcnt_q <= hcnt_d;
            bcnt_q <= bcnt_d;
            sreg_q <= sreg_d;
            rx_q   <= rx_d;
        end
    end

endmodule

// File: rtl/joystick_reader.sv
// PmodJSTK poller: every POLL_PERIOD clocks runs a 5-byte SPI frame and
// commits the quantised X position, raw X and buttons together.
module joystick_reader
    import jstk_pkg::*;
#(
    parameter int         SCK_HALF    = 64,
    parameter int         SS_SETUP    = 1500,
    parameter int         BYTE_GAP    = 1000,
    parameter int         POLL_PERIOD = 1000000,
    parameter logic [3:0] NEUTRAL     = NEUTRAL_CODE
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [1:0]        Leds,
    joystick_reader_if.master jstk,
    output logic [3:0]        Joystick_data,
    output logic [9:0]        Joystick_X_raw,
    output logic [2:0]        Buttons,
    output logic              Sample_valid
);

    localparam int POLL_W = $clog2(POLL_PERIOD);
    localparam int CNT_MX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int CNT_W  = $clog2(CNT_MX + 1);

    jstk_state_e       state_q, state_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [1:0]        leds_q, leds_d;
    logic              ss_n_q, ss_n_d;
    logic [7:0]        x_lo_q, x_lo_d;
    logic [1:0]        x_hi_q, x_hi_d;
    logic [2:0]        btn_q, btn_d;
    logic [3:0]        data_q, data_d;
    logic [9:0]        xraw_q, xraw_d;
    logic [2:0]        buttons_q, buttons_d;
    logic              valid_q, valid_d;

    logic       tick;
    logic       start;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       byte_done;

    assign tick = (poll_q == POLL_W'(POLL_PERIOD - 1));

    // Command byte only in slot 0 of an active frame; everything else sends zero.
    assign tx_byte = ((state_q != IDLE) && (state_q != DONE) && (idx_q == 3'd0))
                     ? {CMD_PREFIX, leds_q} : 8'h00;

    spi_byte_shifter #(.SCK_HALF(SCK_HALF)) u_shifter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (jstk.Jstk_MISO),
        .sck     (jstk.Jstk_SCK),
        .mosi    (jstk.Jstk_MOSI),
        .rx_byte (rx_byte),
        .done    (byte_done)
    );

    assign jstk.Jstk_SS_n = ss_n_q;
    assign Joystick_data  = data_q;
    assign Joystick_X_raw = xraw_q;
    assign Buttons        = buttons_q;
    assign Sample_valid   = valid_q;

    // Frame sequencing, rx capture and the single-cycle commit.
    always_comb begin
        state_d   = state_q;
        poll_d    = tick ? '0 : poll_q + POLL_W'(1);
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        leds_d    = leds_q;
        ss_n_d    = ss_n_q;
        x_lo_d    = x_lo_q;
        x_hi_d    = x_hi_q;
        btn_d     = btn_q;
        data_d    = data_q;
        xraw_d    = xraw_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        start     = 1'b0;
        case (state_q)
            IDLE: begin
                // Ticks elsewhere fall on the floor: only IDLE looks at them.
                if (tick) begin
                    state_d = SETUP;
                    ss_n_d  = 1'b0;
                    cnt_d   = CNT_W'(SS_SETUP - 1);
                    idx_d   = 3'd0;
                    leds_d  = Leds;
                end
            end
            SETUP, GAP: begin
                if (cnt_q == '0) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (byte_done) begin
                    case (idx_q)
                        3'd0:    x_lo_d = rx_byte;
                        3'd1:    x_hi_d = rx_byte[1:0];
                        3'd4:    btn_d  = rx_byte[2:0];
                        default: ;
                    endcase
                    if (idx_q < 3'(FRAME_BYTES - 1)) begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = CNT_W'(BYTE_GAP - 1);
                        state_d = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                ss_n_d    = 1'b1;
                xraw_d    = {x_hi_q, x_lo_q};
                data_d    = {x_hi_q, x_lo_q[7:6]};
                buttons_d = btn_q;
                valid_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any frame and restores neutral outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            poll_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            leds_q    <= 2'd0;
            ss_n_q    <= 1'b1;
            x_lo_q    <= 8'd0;
            x_hi_q    <= 2'd0;
            btn_q     <= 3'd0;
            data_q    <= NEUTRAL;
            xraw_q    <= CENTRE_RAW;
            buttons_q <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            leds_q    <= leds_d;
            ss_n_q    <= ss_n_d;
            x_lo_q    <= x_lo_d;
            x_hi_q    <= x_hi_d;
            btn_q     <= btn_d;
            data_q    <= data_d;
            xraw_q    <= xraw_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_joystick_reader.sv
// Bench for joystick_reader: PmodJSTK slave model, scoreboard of expected
// commits, and bus-timing checks on SS_n/SCK.
module tb_joystick_reader;

    localparam int H     = 2;
    localparam int SETUP = 8;
    localparam int GAPC  = 6;
    localparam int POLL  = 400;

    typedef struct {
        int data;
        int xraw;
        int btn;
        int cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [1:0] Leds;
    logic [3:0] Joystick_data;
    logic [9:0] Joystick_X_raw;
    logic [2:0] Buttons;
    logic       Sample_valid;

    joystick_reader_if jstk ();

    joystick_reader #(
        .SCK_HALF    (H),
        .SS_SETUP    (SETUP),
        .BYTE_GAP    (GAPC),
        .POLL_PERIOD (POLL)
    ) dut (
        .Clk            (clk),
        .Reset_n        (Reset_n),
        .Leds           (Leds),
        .jstk           (jstk),
        .Joystick_data  (Joystick_data),
        .Joystick_X_raw (Joystick_X_raw),
        .Buttons        (Buttons),
        .Sample_valid   (Sample_valid)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [7:0] resp_next[5];
    logic [7:0] resp_cur[5];
    int   rel_cyc = 0;
    int   rise_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: X is the low 10 bits of the little-endian pair, the Player
    // code is X divided into 16 equal bands.
    function automatic exp_t model(input int xlo, input int xhi, input int btn, input int leds);
        exp_t e;
        e.xraw = (xhi % 4) * 256 + xlo;
        e.data = e.xraw / 64;
        e.btn  = btn % 8;
        e.cmd  = 128 + leds;
        return e;
    endfunction

    // Bus monitor, slave model and scoreboard checker.
    logic prev_ss = 1'b1, prev_sck = 1'b0;
    bit   in_frame = 0, start_ok = 0, first_after_rel = 1;
    int   last_start = 0, byte_rise = 0;
    logic [7:0] cmd_rx;
    always @(negedge clk) begin
        logic ss, sck;
        exp_t e;
        ss  = jstk.Jstk_SS_n;
        sck = jstk.Jstk_SCK;
        if (!Reset_n) begin
            in_frame        = 0;
            start_ok        = 0;
            first_after_rel = 1;
            rise_cnt        = 0;
            jstk.Jstk_MISO  = 1'b0;
        end else begin
            if (prev_ss && !ss) begin
                if (first_after_rel) chk("first_frame_start", cyc - rel_cyc, POLL);
                else if (start_ok) chk("frame_spacing", cyc - last_start, POLL);
                first_after_rel = 0;
                start_ok   = 1;
                last_start = cyc;
                in_frame   = 1;
                rise_cnt   = 0;
                cmd_rx     = 8'h00;
                resp_cur   = resp_next;
            end
            if (!prev_sck && sck) begin
                chk("sck_rise_ss_low", int'(ss), 0);
                if (rise_cnt == 0) chk("ss_to_first_sck", cyc - last_start, SETUP);
                else if (rise_cnt % 8 == 0) chk("byte_gap", cyc - (byte_rise + 16 * H), GAPC);
                if (rise_cnt % 8 == 0) byte_rise = cyc;
                if (rise_cnt < 8) cmd_rx = {cmd_rx[6:0], jstk.Jstk_MOSI};
                rise_cnt++;
            end
            if (!prev_ss && ss) chk("valid_with_ss_rise", int'(Sample_valid), 1);
            if (Sample_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_queue", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("joystick_data", int'(Joystick_data), e.data);
                    chk("x_raw", int'(Joystick_X_raw), e.xraw);
                    chk("buttons", int'(Buttons), e.btn);
                    chk("sck_rises_per_frame", rise_cnt, 40);
                    chk("mosi_cmd_byte", int'(cmd_rx), e.cmd);
                    chk("ss_high_at_valid", int'(ss), 1);
                end
                in_frame = 0;
            end
            if (!ss && !sck) begin
                if (rise_cnt < 40) jstk.Jstk_MISO = resp_cur[rise_cnt / 8][7 - (rise_cnt % 8)];
                else jstk.Jstk_MISO = 1'b0;
            end
        end
        prev_ss  = ss;
        prev_sck = sck;
    end

    task automatic prep(input int xlo, input int xhi, input int ylo, input int yhi,
                        input int btn, input int leds);
        resp_next[0] = 8'(xlo);
        resp_next[1] = 8'(xhi);
        resp_next[2] = 8'(ylo);
        resp_next[3] = 8'(yhi);
        resp_next[4] = 8'(btn);
        Leds = 2'(leds);
        exp_q.push_back(model(xlo, xhi, btn, leds));
    endtask

    task automatic wait_ss(input logic level, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (jstk.Jstk_SS_n === level) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_frame(input int xlo, input int xhi, input int ylo, input int yhi,
                             input int btn, input int leds, input bit do_release);
        bit ok;
        prep(xlo, xhi, ylo, yhi, btn, leds);
        if (do_release) begin
            @(negedge clk);
            rel_cyc = cyc;
            Reset_n = 1'b1;
        end
        wait_ss(1'b0, POLL + 50, ok);
        chk("ss_fall_timeout", int'(ok), 1);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        Leds = 2'($urandom);
        wait_ss(1'b1, 300, ok);
        chk("ss_rise_timeout", int'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_frame(input int xlo, input int xhi, input int btn);
        bit ok;
        prep(xlo, xhi, 8'h11, 8'h22, btn, 3);
        wait_ss(1'b0, POLL + 50, ok);
        chk("abort_ss_fall_timeout", int'(ok), 1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_cnt >= 18) begin
                ok = 1;
                break;
            end
        end
        chk("abort_reach_byte2", int'(ok), 1);
        Reset_n = 1'b0;
        #1;
        chk("abort_ss_n", int'(jstk.Jstk_SS_n), 1);
        chk("abort_sck", int'(jstk.Jstk_SCK), 0);
        chk("abort_data", int'(Joystick_data), 5);
        chk("abort_x_raw", int'(Joystick_X_raw), 352);
        chk("abort_buttons", int'(Buttons), 0);
        chk("abort_valid", int'(Sample_valid), 0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0;
        Leds    = 2'b00;
        jstk.Jstk_MISO = 1'b0;
        for (int i = 0; i < 5; i++) resp_next[i] = 8'h00;
        resp_cur = resp_next;
        repeat (3) @(negedge clk);
        chk("reset_data", int'(Joystick_data), 5);
        chk("reset_x_raw", int'(Joystick_X_raw), 352);
        chk("reset_buttons", int'(Buttons), 0);
        chk("reset_valid", int'(Sample_valid), 0);
        chk("reset_ss_n", int'(jstk.Jstk_SS_n), 1);
        chk("reset_sck", int'(jstk.Jstk_SCK), 0);
        chk("reset_mosi", int'(jstk.Jstk_MOSI), 0);

        // Full left, then full right with junk in X_hi[7:2], then the neutral band.
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1);
        run_frame(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        run_frame(8'h7F, 8'h01, 8'h3C, 8'h02, 8'h00, 2, 1'b0);
        run_frame(8'hC0, 8'h01, 8'hFF, 8'h03, 8'h00, 3, 1'b0);
        run_frame(8'hFF, 8'h00, 8'h00, 8'h00, 8'h05, 0, 1'b0);

        for (int f = 0; f < 5; f++) begin
            run_frame(int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(255)), int'($urandom_range(3)), 1'b0);
        end

        abort_frame(8'h40, 8'h02, 8'h07);
        run_frame(8'h2A, 8'hFE, 8'h55, 8'hAA, 8'h03, 2, 1'b1);
        run_frame(int'($urandom_range(255)), int'($urandom_range(255)), 8'h00, 8'h00,
                  int'($urandom_range(255)), int'($urandom_range(3)), 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
